eth_rx_framer: RTL
==================

Name: eth_rx_framer

Overview:
- Bit-serial Ethernet receive framer that runs one stage upstream of the bit-serial FCS residue checker.
- Hunts for preamble and SFD, then drives the checker with every frame bit, including the FCS bits.
- Assembles bytes LSB-first and strips the 4 FCS bytes through a 4-byte delay line.
- At end of carrier, emits a one-cycle end-of-frame status pulse combining checker result, alignment and length checks.

Parameters:
- MIN_FRAME, 64, minimum legal frame length in bytes, DA through FCS inclusive.
- MAX_FRAME, 1518, maximum legal frame length in bytes, DA through FCS inclusive.
- MAX_PRE_BITS, 96, bits allowed in hunt state before the SFD must be seen.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- rx_dv  in  1  carrier/data valid from the line decoder
- rx_bit_en  in  1  qualifies rx_bit; one received bit per asserted cycle
- rx_bit  in  1  received bit, wire order (LSB of each byte first)
- fcs_clr  out  1  to checker reset; holds checker at all-ones
- fcs_en  out  1  to checker enable
- fcs_bit  out  1  to checker data input
- crc_ok  in  1  checker residue-match flag
- out_valid  out  1  one-cycle payload byte strobe
- out_data  out  8  payload byte
- out_sof  out  1  marks first payload byte of the frame (with out_valid)
- out_eof  out  1  one-cycle end-of-frame pulse, out_valid=0 in that cycle
- out_good  out  1  frame good; valid with out_eof
- out_err_crc  out  1  FCS residue mismatch; valid with out_eof
- out_err_len  out  1  runt or oversize; valid with out_eof
- out_err_align  out  1  non-byte-multiple bit count; valid with out_eof
- out_len  out  11  payload bytes (total minus 4, floor 0); valid with out_eof

Behaviour:
- Reset: state IDLE. All out_* are 0. fcs_en=0, fcs_clr=1. Delay line and counters cleared. Reset mid-frame aborts silently with no out_eof.
- A "bit" is a cycle with rx_dv && rx_bit_en. rx_bit_en while rx_dv=0 is ignored.
- fcs_clr = (state != DATA), combinational from state.
- fcs_en = (state == DATA) && bit; fcs_bit = rx_bit, combinational pass-through.
- IDLE: on rx_dv=1, go to HUNT and clear the shift register and hunt counter. If that same cycle carries a bit, process it as HUNT.
- HUNT:
  - Each bit shifts into an 8-bit register from the MSB end (sr <= {rx_bit, sr[7:1]}); hunt counter increments.
  - If the new sr == 8'hD5, go to DATA with bit count = 0 and byte count = 0.
  - Else, if the counter reaches MAX_PRE_BITS, go to DROP.
  - rx_dv=0 returns to IDLE, no out_eof.
- DROP: ignore input; return to IDLE when rx_dv=0; no out_eof.
- DATA, per bit:
  - Shift into the byte register; bit count increments mod 8.
  - When the 8th bit lands, the byte is complete and byte count increments, saturating at 2047.
  - Completed byte enters the 4-entry delay line. If the line already held 4 bytes, its oldest byte is emitted next cycle: out_valid=1, out_data=that byte, out_sof=1 only for the first emission of the frame.
  - Once byte count > MAX_FRAME, out_valid is suppressed for the rest of the frame.
- DATA, on rx_dv=0 (one cycle after the last bit edge):
  - Evaluate the frame: err_crc = !crc_ok; err_align = (bit count != 0); err_len = (bytes < MIN_FRAME) || (bytes > MAX_FRAME); good = none of the three.
  - Next cycle: out_eof=1 carrying those flags and out_len. Delay line is discarded (it holds the FCS). State returns to IDLE.
  - Any trailing partial-byte bits are fed to the checker but never emitted.
- Payload latency: the byte appears on out_data one clk after the last bit of the 4th following byte.
- Simultaneous rx_dv fall and rx_bit_en: no bit is taken, since rx_dv gates it.
- Back-to-back frames need rx_dv low for at least 1 cycle; IDLE is entered in the out_eof cycle.

Decomposition:
- Package eth_pkg:
  - constants ETH_SFD=8'hD5, ETH_FCS_BYTES=4.
  - enum rx_state_t {IDLE, HUNT, DATA, DROP}.
  - struct eof status type {good, err_crc, err_len, err_align, len[10:0]}.
- Sub-module eth_rx_delay4: 4-entry byte delay line with an occupancy count, push/pop and a flush input.
- The FCS checker is instantiated by the parent next to this block, not inside it.

Test Plan:
- 7x 0x55, 0xD5, 60-byte payload with correct FCS, checker attached → 60 out_valid (first with out_sof); out_eof with good=1, len=60, all errors 0.
- Same frame with payload byte 10 bit 3 flipped → 60 bytes emitted; out_eof good=0, err_crc=1.
- Correct frame followed by 3 extra bits before rx_dv falls → out_eof err_align=1, good=0.
- 20-byte frame with valid FCS → 16 bytes emitted; out_eof err_len=1, len=16.
- 100 preamble bits with no SFD → enters DROP at bit 96; no out_valid, no out_eof; next frame is received normally.
- reset asserted at payload byte 30 → all outputs 0 next cycle, no out_eof; subsequent good frame reports good=1.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared types and constants for the bit-serial Ethernet receive path.
package eth_pkg;

    localparam logic [7:0]  ETH_SFD       = 8'hD5;
    localparam int unsigned ETH_FCS_BYTES = 4;
    localparam int unsigned ETH_LEN_W     = 11;

    typedef enum logic [1:0] {
        IDLE,
        HUNT,
        DATA,
        DROP
    } rx_state_t;

    typedef struct packed {
        logic                 good;
        logic                 err_crc;
        logic                 err_len;
        logic                 err_align;
        logic [ETH_LEN_W-1:0] len;
    } eof_status_t;

    // Payload length excluding the FCS, floored at zero for runts.
    function automatic logic [ETH_LEN_W-1:0] payload_len(input logic [ETH_LEN_W-1:0] total);
        if (total >= ETH_LEN_W'(ETH_FCS_BYTES)) begin
            return total - ETH_LEN_W'(ETH_FCS_BYTES);
        end
        return '0;
    endfunction

endpackage

// File: rtl/eth_rx_delay4.sv
// Byte delay line that holds back the trailing FCS bytes of a frame.
module eth_rx_delay4
    import eth_pkg::*;
(
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 flush,
    input  logic                                 push,
    input  logic                                 pop,
    input  logic [7:0]                           push_data,
    output logic [7:0]                           pop_data,
    output logic [$clog2(ETH_FCS_BYTES + 1)-1:0] count
);

    localparam int unsigned DEPTH = ETH_FCS_BYTES;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned IDX_W = $clog2(DEPTH);

    logic [7:0]       mem_q [DEPTH];
    logic [7:0]       mem_d [DEPTH];
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign pop_data = mem_q[0];
    assign count    = cnt_q;

    // Entry 0 is always the oldest byte; a pop shifts everything down one slot.
    always_comb begin
        mem_d = mem_q;
        cnt_d = cnt_q;
        if (flush) begin
            cnt_d = '0;
        end else if (pop && cnt_q != '0) begin
            for (int unsigned i = 0; i < DEPTH - 1; i++) begin
                mem_d[i] = mem_q[i+1];
            end
            if (push) begin
                mem_d[IDX_W'(cnt_q - CNT_W'(1))] = push_data;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end else if (push && cnt_q != CNT_W'(DEPTH)) begin
            mem_d[IDX_W'(cnt_q)] = push_data;
            cnt_d                = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
            mem_q <= mem_d;
        end
    end

endmodule

// File: rtl/eth_rx_framer.sv
// Bit-serial Ethernet receive framer: SFD hunt, byte assembly, FCS stripping and
// end-of-frame status. The FCS residue checker sits beside this block.
module eth_rx_framer
    import eth_pkg::*;
#(
    parameter int unsigned MIN_FRAME    = 64,
    parameter int unsigned MAX_FRAME    = 1518,
    parameter int unsigned MAX_PRE_BITS = 96
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx_dv,
    input  logic                 rx_bit_en,
    input  logic                 rx_bit,
    output logic                 fcs_clr,
    output logic                 fcs_en,
    output logic                 fcs_bit,
    input  logic                 crc_ok,
    output logic                 out_valid,
    output logic [7:0]           out_data,
    output logic                 out_sof,
    output logic                 out_eof,
    output logic                 out_good,
    output logic                 out_err_crc,
    output logic                 out_err_len,
    output logic                 out_err_align,
    output logic [ETH_LEN_W-1:0] out_len
);

    localparam int unsigned HUNT_W = $clog2(MAX_PRE_BITS + 1);
    localparam int unsigned CNT_W  = $clog2(ETH_FCS_BYTES + 1);

    rx_state_t            state_q, state_d;
    logic [7:0]           sr_q, sr_d, sr_base, sr_next;
    logic [HUNT_W-1:0]    hunt_q, hunt_d, hunt_base, hunt_next;
    logic [2:0]           bit_cnt_q, bit_cnt_d;
    logic [ETH_LEN_W-1:0] byte_cnt_q, byte_cnt_d, byte_cnt_inc;
    logic                 first_q, first_d;
    logic                 valid_q, valid_d;
    logic                 sof_q, sof_d;
    logic                 eof_q, eof_d;
    logic [7:0]           data_q, data_d;
    eof_status_t          status_q, status_d;

    logic                 bit_in;
    logic                 too_short, too_long;
    logic                 dl_push, dl_pop, dl_flush, dl_full;
    logic [7:0]           dl_pop_data;
    logic [CNT_W-1:0]     dl_count;

    assign bit_in  = rx_dv & rx_bit_en;
    assign fcs_clr = (state_q != DATA);
    assign fcs_en  = (state_q == DATA) & bit_in;
    assign fcs_bit = rx_bit;

    // Entering from IDLE starts the hunt from a cleared register and counter.
    assign sr_base      = (state_q == IDLE) ? '0 : sr_q;
    assign hunt_base    = (state_q == IDLE) ? '0 : hunt_q;
    assign sr_next      = {rx_bit, sr_base[7:1]};
    assign hunt_next    = hunt_base + 1'b1;
    assign byte_cnt_inc = (byte_cnt_q == '1) ? byte_cnt_q : byte_cnt_q + 1'b1;
    assign too_short    = byte_cnt_q < ETH_LEN_W'(MIN_FRAME);
    assign too_long     = byte_cnt_q > ETH_LEN_W'(MAX_FRAME);

    assign dl_full = (dl_count == CNT_W'(ETH_FCS_BYTES));
    assign dl_pop  = dl_push & dl_full;

    eth_rx_delay4 u_delay (
        .clk       (clk),
        .reset     (reset),
        .flush     (dl_flush),
        .push      (dl_push),
        .pop       (dl_pop),
        .push_data (sr_next),
        .pop_data  (dl_pop_data),
        .count     (dl_count)
    );

    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        hunt_d     = hunt_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        first_d    = first_q;
        valid_d    = 1'b0;
        sof_d      = 1'b0;
        data_d     = data_q;
        eof_d      = 1'b0;
        status_d   = '0;
        dl_push    = 1'b0;
        dl_flush   = 1'b0;

        unique case (state_q)
            IDLE, HUNT: begin
                if (!rx_dv) begin
                    state_d = IDLE;
                end else begin
                    state_d = HUNT;
                    sr_d    = sr_base;
                    hunt_d  = hunt_base;
                    if (bit_in) begin
                        sr_d   = sr_next;
                        hunt_d = hunt_next;
                        if (sr_next == ETH_SFD) begin
                            state_d    = DATA;
                            bit_cnt_d  = '0;
                            byte_cnt_d = '0;
                            first_d    = 1'b1;
                            dl_flush   = 1'b1;
                        end else if (hunt_next == HUNT_W'(MAX_PRE_BITS)) begin
                            state_d = DROP;
                        end
                    end
                end
            end
            DATA: begin
                if (!rx_dv) begin
                    state_d            = IDLE;
                    dl_flush           = 1'b1;
                    eof_d              = 1'b1;
                    status_d.err_crc   = !crc_ok;
                    status_d.err_align = (bit_cnt_q != '0);
                    status_d.err_len   = too_short | too_long;
                    status_d.good      = crc_ok && (bit_cnt_q == '0) && !too_short && !too_long;
                    status_d.len       = payload_len(byte_cnt_q);
                end else if (bit_in) begin
                    sr_d      = sr_next;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        byte_cnt_d = byte_cnt_inc;
                        dl_push    = 1'b1;
                        // Oldest byte leaves only once four newer bytes prove it is not FCS.
                        if (dl_full && byte_cnt_inc <= ETH_LEN_W'(MAX_FRAME)) begin
                            valid_d = 1'b1;
                            data_d  = dl_pop_data;
                            sof_d   = first_q;
                            first_d = 1'b0;
                        end
                    end
                end
            end
            DROP: begin
                if (!rx_dv) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            sr_q       <= '0;
            hunt_q     <= '0;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            first_q    <= 1'b0;
            valid_q    <= 1'b0;
            sof_q      <= 1'b0;
            data_q     <= '0;
            eof_q      <= 1'b0;
            status_q   <= '0;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            hunt_q     <= hunt_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            first_q    <= first_d;
            valid_q    <= valid_d;
            sof_q      <= sof_d;
            data_q     <= data_d;
            eof_q      <= eof_d;
            status_q   <= status_d;
        end
    end

    assign out_valid     = valid_q;
    assign out_data      = data_q;
    assign out_sof       = sof_q;
    assign out_eof       = eof_q;
    assign out_good      = status_q.good;
    assign out_err_crc   = status_q.err_crc;
    assign out_err_len   = status_q.err_len;
    assign out_err_align = status_q.err_align;
    assign out_len       = status_q.len;

endmodule
